// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data requests onto a single word-wide RAM port; data wins ties.
// Optional MEM_ARBITER_ALIGN_CHECK_EN adds dmem_misalign and rejects misaligned half/word accesses.
module mem_arbiter #(
  parameter int LDST_WIDTH_W = 2
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    imem_ren,
  input  logic [31:0]             imem_addr,
  output logic [31:0]             imem_load,
  output logic                    ihit,
  input  logic                    dmem_ren,
  input  logic                    dmem_wen,
  input  logic [31:0]             dmem_addr,
  input  logic [31:0]             dmem_store,
  input  logic [LDST_WIDTH_W-1:0] dmem_width,
  output logic [31:0]             dmem_load,
  output logic                    dhit,
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
  output logic                    dmem_misalign,
`endif
  output logic                    ram_ren,
  output logic                    ram_wen,
  output logic [31:0]             ram_addr,
  output logic [3:0]              ram_byteen,
  output logic [31:0]             ram_store,
  input  logic [31:0]             ram_load,
  input  logic                    ram_ready
);

  // state | meaning
  // IDLE  | waiting for a request; data has priority
  // IACC  | instruction read on RAM, waiting for ram_ready
  // DACC  | data read/write on RAM, waiting for ram_ready
  // IDONE | ihit pulse
  // DDONE | dhit pulse
  typedef enum logic [2:0] {IDLE, IACC, DACC, IDONE, DDONE} state_t;

  state_t      state;
  logic [1:0]  lat_width;
  logic [1:0]  lat_lo;
  logic        lat_write;
  logic        skip;

  function automatic logic [3:0] lane_en(input logic [1:0] w, input logic [1:0] a);
    case (w)
      2'd0:    lane_en = 4'b0001 << a;
      2'd1:    lane_en = a[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input logic [1:0] w, input logic [31:0] s);
    case (w)
      2'd0:    store_rep = {4{s[7:0]}};
      2'd1:    store_rep = {2{s[15:0]}};
      default: store_rep = s;
    endcase
  endfunction

  function automatic logic [31:0] load_sel(input logic [1:0] w, input logic [1:0] a,
                                           input logic [31:0] d);
    case (w)
      2'd0: begin
        case (a)
          2'd0:    load_sel = {24'h0, d[7:0]};
          2'd1:    load_sel = {24'h0, d[15:8]};
          2'd2:    load_sel = {24'h0, d[23:16]};
          default: load_sel = {24'h0, d[31:24]};
        endcase
      end
      2'd1:    load_sel = a[1] ? {16'h0, d[31:16]} : {16'h0, d[15:0]};
      default: load_sel = d;
    endcase
  endfunction

`ifdef MEM_ARBITER_ALIGN_CHECK_EN
  // Width codes 2 and 3 are both word accesses.
  function automatic logic is_misaligned(input logic [1:0] w, input logic [1:0] a);
    is_misaligned = (w == 2'd1 && a[0]) || (w[1] && a != 2'd0);
  endfunction

  assign skip = is_misaligned(dmem_width, dmem_addr[1:0]);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      lat_width  <= 2'd0;
      lat_lo     <= 2'd0;
      lat_write  <= 1'b0;
      ihit       <= 1'b0;
      dhit       <= 1'b0;
      imem_load  <= 32'h0;
      dmem_load  <= 32'h0;
      ram_ren    <= 1'b0;
      ram_wen    <= 1'b0;
      ram_addr   <= 32'h0;
      ram_byteen <= 4'h0;
      ram_store  <= 32'h0;
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
      dmem_misalign <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (dmem_ren || dmem_wen) begin
            lat_width  <= dmem_width;
            lat_lo     <= dmem_addr[1:0];
            lat_write  <= dmem_wen;
            ram_addr   <= dmem_addr & ~32'd3;
            ram_byteen <= lane_en(dmem_width, dmem_addr[1:0]);
            ram_store  <= store_rep(dmem_width, dmem_store);
            if (skip) begin
              dhit  <= 1'b1;
              state <= DDONE;
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
              dmem_misalign <= 1'b1;
`endif
            end else begin
              ram_ren <= !dmem_wen;
              ram_wen <= dmem_wen;
              state   <= DACC;
            end
          end else if (imem_ren) begin
            ram_addr   <= imem_addr & ~32'd3;
            ram_byteen <= 4'hF;
            ram_store  <= 32'h0;
            ram_ren    <= 1'b1;
            state      <= IACC;
          end
        end
        IACC: begin
          if (ram_ready) begin
            ram_ren   <= 1'b0;
            imem_load <= ram_load;
            ihit      <= 1'b1;
            state     <= IDONE;
          end
        end
        DACC: begin
          if (ram_ready) begin
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            if (!lat_write) dmem_load <= load_sel(lat_width, lat_lo, ram_load);
            dhit    <= 1'b1;
            state   <= DDONE;
          end
        end
        IDONE: begin
          ihit  <= 1'b0;
          state <= IDLE;
        end
        DDONE: begin
          dhit  <= 1'b0;
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
          dmem_misalign <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
